// File: rtl/param_ins_cache_pkg.sv
// Shared FSM state type and elaboration-time helpers for the parameterised instruction cache.
package ins_cache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    REFILL
  } state_t;

  // Ceiling log2; the top compares 2**result back against the parameter to reject non-powers of two.
  function automatic int log2c(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/param_ins_cache_store.sv
// Line storage for param_ins_cache: data, tag and valid arrays with one write port
// and one asynchronous read port.
module param_ins_cache_store #(
  parameter int NUM_LINES = 8,
  parameter int LINE_BITS = 128,
  parameter int TAG_W     = 25,
  parameter int IDX_W     = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 write,
  input  logic [IDX_W-1:0]     write_index,
  input  logic [TAG_W-1:0]     write_tag,
  input  logic [LINE_BITS-1:0] write_line,
  input  logic                 clear_all,
  input  logic [IDX_W-1:0]     read_index,
  output logic [TAG_W-1:0]     read_tag,
  output logic [LINE_BITS-1:0] read_line,
  output logic                 read_valid
);

  logic [LINE_BITS-1:0] data_mem [NUM_LINES];
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [NUM_LINES-1:0] valid;

  always_ff @(posedge clock) begin
    if (write) begin
      data_mem[write_index] <= write_line;
      tag_mem[write_index]  <= write_tag;
    end
  end

  // A clear issued together with a write wins, so a line refilled under a pending flush ends invalid.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid <= '0;
    end else if (clear_all) begin
      valid <= '0;
    end else if (write) begin
      valid[write_index] <= 1'b1;
    end
  end

  assign read_line  = data_mem[read_index];
  assign read_tag   = tag_mem[read_index];
  assign read_valid = valid[read_index];

endmodule

// File: rtl/param_ins_cache.sv
// Direct-mapped instruction cache with zero-wait hits and a blocking whole-line refill.
// Define ICACHE_STATS_EN to add saturating hit_count / miss_count outputs.
module param_ins_cache
  import ins_cache_pkg::*;
#(
  parameter int  ADDR_W     = 32,
  parameter int  NUM_LINES  = 8,
  parameter int  LINE_WORDS = 4,
  localparam int OFF_W      = log2c(LINE_WORDS),
  localparam int IDX_W      = log2c(NUM_LINES),
  localparam int TAG_W      = ADDR_W - IDX_W - OFF_W - 2,
  localparam int MEM_AW     = ADDR_W - OFF_W - 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      read,
  input  logic [ADDR_W-1:0]         address,
  output logic [31:0]               readdata,
  output logic                      busywait,
  input  logic                      flush,
  output logic                      mem_read,
  output logic [MEM_AW-1:0]         mem_address,
  input  logic [32*LINE_WORDS-1:0]  mem_readdata,
  input  logic                      mem_busywait
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]               hit_count,
  output logic [31:0]               miss_count
`endif
);

  localparam int OFF_SW    = (OFF_W > 0) ? OFF_W : 1;
  localparam int LINE_BITS = 32 * LINE_WORDS;

  if (NUM_LINES < 2 || (1 << IDX_W) != NUM_LINES) begin : g_bad_num_lines
    $error("param_ins_cache: NUM_LINES must be a power of two and at least 2");
  end
  if (LINE_WORDS < 1 || (1 << OFF_W) != LINE_WORDS) begin : g_bad_line_words
    $error("param_ins_cache: LINE_WORDS must be a power of two and at least 1");
  end

  state_t               state;
  state_t               next_state;
  logic [OFF_SW-1:0]    offset;
  logic [IDX_W-1:0]     index;
  logic [IDX_W-1:0]     index_q;
  logic [TAG_W-1:0]     tag;
  logic [TAG_W-1:0]     tag_q;
  logic [TAG_W-1:0]     store_tag;
  logic [LINE_BITS-1:0] store_line;
  logic [LINE_BITS-1:0] line_q;
  logic                 store_valid;
  logic                 hit;
  logic                 miss;
  logic                 refill;
  logic                 flush_pending;
  logic                 clear_all;
  logic [31:0]          hit_word;
  logic [31:0]          readdata_q;
  logic                 unused_addr_bits;

  if (OFF_W > 0) begin : g_offset
    assign offset = address[OFF_W+1:2];
  end else begin : g_no_offset
    assign offset = '0;
  end

  assign index            = address[IDX_W+OFF_W+1:OFF_W+2];
  assign tag              = address[ADDR_W-1:IDX_W+OFF_W+2];
  assign unused_addr_bits = ^address[1:0];

  param_ins_cache_store #(
    .NUM_LINES (NUM_LINES),
    .LINE_BITS (LINE_BITS),
    .TAG_W     (TAG_W),
    .IDX_W     (IDX_W)
  ) u_store (
    .clock       (clock),
    .reset       (reset),
    .write       (refill),
    .write_index (index_q),
    .write_tag   (tag_q),
    .write_line  (line_q),
    .clear_all   (clear_all),
    .read_index  (index),
    .read_tag    (store_tag),
    .read_line   (store_line),
    .read_valid  (store_valid)
  );

  assign hit_word = store_line[{offset, 5'd0} +: 32];
  assign hit      = (state == IDLE) && read && store_valid && (store_tag == tag);
  // Reset is asynchronous, so the stall is also held low while it is asserted.
  assign miss     = reset && (state == IDLE) && read && !hit;
  assign refill   = (state == REFILL);
  assign clear_all = ((state == IDLE) && flush) || (refill && (flush || flush_pending));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    busywait   = 1'b0;
    mem_read   = 1'b0;
    readdata   = readdata_q;
    case (state)
      IDLE: begin
        if (hit) readdata = hit_word;
        if (miss) begin
          busywait   = 1'b1;
          next_state = FETCH;
        end
      end
      FETCH: begin
        busywait = 1'b1;
        mem_read = 1'b1;
        if (!mem_busywait) next_state = REFILL;
      end
      REFILL: begin
        busywait   = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // The missed line address is frozen here so the pipeline may move address during the refill.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tag_q   <= '0;
      index_q <= '0;
    end else if (miss) begin
      tag_q   <= tag;
      index_q <= index;
    end
  end

  assign mem_address = {tag_q, index_q};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      line_q <= '0;
    end else if ((state == FETCH) && !mem_busywait) begin
      line_q <= mem_readdata;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      flush_pending <= 1'b0;
    end else if (refill) begin
      flush_pending <= 1'b0;
    end else if (flush && (state != IDLE)) begin
      flush_pending <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      readdata_q <= '0;
    end else if (hit) begin
      readdata_q <= hit_word;
    end
  end

`ifdef ICACHE_STATS_EN
  logic after_refill;

  // The hit that completes a miss is not counted as a hit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      after_refill <= 1'b0;
    end else begin
      after_refill <= refill;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit && !after_refill && (hit_count != 32'hFFFF_FFFF)) hit_count <= hit_count + 32'd1;
      if (miss && (miss_count != 32'hFFFF_FFFF)) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: doc/param_ins_cache.md
PARAM_INS_CACHE -- requirements
Module: param_ins_cache

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: instruction address width.
REQ-002 SHALL have parameter NUM_LINES, default 8: number of cache lines; power of two, at least 2.
REQ-003 SHALL have parameter LINE_WORDS, default 4: 32-bit words per line; power of two, at least 1.
REQ-004 SHALL define derived widths: OFF_W=log2(LINE_WORDS), IDX_W=log2(NUM_LINES), TAG_W=ADDR_W-IDX_W-OFF_W-2, MEM_AW=ADDR_W-OFF_W-2.
REQ-005 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port read, input, 1 bit: fetch request.
REQ-008 SHALL have port address, input, ADDR_W bits: PC; bits [1:0] ignored.
REQ-009 SHALL have port readdata, output, 32 bits: fetched instruction.
REQ-010 SHALL have port busywait, output, 1 bit: stall to the pipeline.
REQ-011 SHALL have port flush, input, 1 bit: single-cycle invalidate-all request (fence.i).
REQ-012 SHALL have port mem_read, output, 1 bit: main-memory line read request.
REQ-013 SHALL have port mem_address, output, MEM_AW bits: line address {tag,index}.
REQ-014 SHALL have port mem_readdata, input, 32*LINE_WORDS bits: refill line; word 0 in bits [31:0].
REQ-015 SHALL have port mem_busywait, input, 1 bit: memory busy; line is valid in the cycle this is low while mem_read is high.

Function
REQ-016 SHALL decode offset=address[OFF_W+1:2], index=address[IDX_W+OFF_W+1:OFF_W+2], tag=address[ADDR_W-1:IDX_W+OFF_W+2]; the full tag is stored.
REQ-017 SHALL implement FSM states IDLE, FETCH, REFILL.
REQ-018 Hit (IDLE, read=1, valid[index]=1, tag match) SHALL drive readdata with the selected word combinationally in the same cycle, with busywait=0 (zero-wait hit).
REQ-019 Miss in IDLE SHALL raise busywait combinationally, latch tag and index, and transition to FETCH on the next edge.
REQ-020 FETCH SHALL hold mem_read=1 and mem_address={latched tag, latched index}; it SHALL move to REFILL on the first edge with mem_busywait=0, capturing mem_readdata.
REQ-021 REFILL SHALL write data, tag and valid=1 for the latched index, drop mem_read, keep busywait=1, and return to IDLE; the hit is then served there, giving a miss penalty of memory latency plus 2 cycles.
REQ-022 Changes to address during FETCH or REFILL SHALL NOT affect the in-flight refill; the request is re-evaluated in IDLE.
REQ-023 With read=0, busywait SHALL be 0 and readdata SHALL hold its last value; no FSM activity SHALL occur.
REQ-024 Flush in IDLE SHALL clear all valid bits on that edge; a hit with flush in the same cycle SHALL still be served.
REQ-025 Flush in FETCH or REFILL SHALL be recorded as pending and applied on the REFILL-to-IDLE edge, invalidating the refilled line too; busywait SHALL stay 1 until then.

Reset
REQ-026 reset=0 SHALL immediately force: state=IDLE, all valid bits 0, mem_read=0, mem_address=0, readdata=0, busywait=0, pending flush cleared, counters 0.
REQ-027 Reset asserted mid-FETCH SHALL abort the refill, with mem_read dropping asynchronously; no line SHALL be written.

Configuration
REQ-028 With macro ICACHE_STATS_EN defined, SHALL add 32-bit output ports hit_count and miss_count.
REQ-029 hit_count SHALL increment on IDLE hits not immediately following REFILL; miss_count SHALL increment on each IDLE-to-FETCH transition; both SHALL saturate at 32'hFFFF_FFFF.
REQ-030 Without ICACHE_STATS_EN, the ports and counters SHALL be absent and the remaining behaviour SHALL be identical.

Structure
REQ-031 Package ins_cache_pkg SHALL hold the FSM state enum and a log2 constant function; derived widths SHALL be computed locally from parameters.
REQ-032 Sub-module param_ins_cache_store SHALL hold the data, tag and valid arrays, with one write port and one asynchronous read port.
REQ-033 Non-power-of-two NUM_LINES or LINE_WORDS SHALL cause an elaboration error.

Verification
REQ-034 Cold read 0x0000_0040, memory busy for 5 cycles, line 128'h44443333_22221111_BBBBAAAA_DEADBEEF: mem_address=0x000_0004, busywait high for 7 cycles, readdata=0xDEADBEEF; a following read of 0x44 returns 0xBBBBAAAA with zero wait.
REQ-035 After REQ-034, read 0x0000_00C0 (same index 4, different tag): miss, and the new line replaces the old one; a re-read of 0x40 misses again.
REQ-036 Flush pulsed in IDLE, then read 0x40: miss. Flush pulsed during FETCH: busywait stays high through REFILL and the next read of 0x40 misses.
REQ-037 reset=0 asserted 2 cycles into FETCH: mem_read goes to 0 the same cycle, and after release a read of 0x40 misses.
REQ-038 With ICACHE_STATS_EN, sequence 0x40, 0x44, 0x48, 0xC0: hit_count=2, miss_count=2. With LINE_WORDS=8 and NUM_LINES=16, the REQ-034 scenario repeated gives mem_address=0x000_0002.
